mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus handshake, byte-lane
// steering for stores, load extraction/extension, misalignment and timeout flags.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    input  logic        mem_rd,
    input  logic [2:0]  mem_type,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_adel,
    output logic        mem_ades,
    output logic        mem_buserr
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        buserr_reg, buserr_next;

    logic        req;
    logic        adel;
    logic        ades;

    // Access decode
    logic is_byte, is_half, is_signed, is_load, access, misaligned;
    assign is_byte    = (mem_type == 3'b011) || (mem_type == 3'b100);
    assign is_half    = (mem_type == 3'b001) || (mem_type == 3'b010);
    assign is_signed  = (mem_type == 3'b001) || (mem_type == 3'b011);
    assign is_load    = mem_rd && !mem_we;
    assign access     = mem_we || mem_rd;
    assign misaligned = is_byte ? 1'b0 :
                        is_half ? mem_addr[0] :
                                  (mem_addr[1:0] != 2'b00);

    // Per-lane read bytes and byte-select enables
    logic [7:0] rd_byte [4];
    logic [3:0] byte_sel;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi]  = dbus_rdata[8*gi +: 8];
            assign byte_sel[gi] = (mem_addr[1:0] == 2'(gi));
        end
    endgenerate

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    assign load_byte = rd_byte[mem_addr[1:0]];
    assign load_half = mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    always_comb begin
        load_ext = dbus_rdata;
        if (is_byte) begin
            load_ext = {{24{is_signed & load_byte[7]}}, load_byte};
        end else if (is_half) begin
            load_ext = {{16{is_signed & load_half[15]}}, load_half};
        end
    end

    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = mem_data;
        if (is_byte) begin
            be_raw    = byte_sel;
            wdata_raw = {4{mem_data[7:0]}};
        end else if (is_half) begin
            be_raw    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_raw = {2{mem_data[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            rdata_reg  <= 32'd0;
            buserr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rdata_reg  <= rdata_next;
            buserr_reg <= buserr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rdata_next  = rdata_reg;
        buserr_next = 1'b0;
        req         = 1'b0;
        adel        = 1'b0;
        ades        = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = 8'd0;
                if (access) begin
                    if (misaligned) begin
                        adel = is_load;
                        ades = mem_we;
                    end else begin
                        req = 1'b1;
                        if (dbus_ack) begin
                            state_next = DONE;
                            rdata_next = load_ext;
                        end else begin
                            state_next = WAIT;
                            cnt_next   = 8'd1;
                        end
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dbus_ack) begin
                    state_next = DONE;
                    rdata_next = load_ext;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    state_next  = DONE;
                    buserr_next = 1'b1;
                    rdata_next  = 32'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            req  = 1'b0;
            adel = 1'b0;
            ades = 1'b0;
        end
    end

    // Bus-side fields follow the stalled inputs; reset blanks every one of them
    assign dbus_req   = req;
    assign mem_stall  = req;
    assign dbus_we    = mem_we & ~rst;
    assign dbus_addr  = rst ? 32'd0 : {mem_addr[31:2], 2'b00};
    assign dbus_wdata = rst ? 32'd0 : wdata_raw;
    assign dbus_be    = rst ? 4'd0 : be_raw;
    assign mem_adel   = adel;
    assign mem_ades   = ades;
    assign mem_rdata  = rdata_reg;
    assign mem_buserr = buserr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases then random accesses, each
// checked against a size/offset arithmetic model of the memory access rules.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_rd;
    logic [2:0]  mem_type;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_adel;
    logic        mem_ades;
    logic        mem_buserr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_rd(mem_rd), .mem_type(mem_type),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_buserr(mem_buserr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and signedness from mem_type
    function automatic int unsigned m_size(input logic [2:0] ty);
        if (ty == 3'd1 || ty == 3'd2) return 2;
        if (ty == 3'd3 || ty == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_signed(input logic [2:0] ty);
        return (ty == 3'd1 || ty == 3'd3);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] ty, input logic [31:0] a);
        int unsigned sz = m_size(ty);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] ty, input logic [31:0] d);
        int unsigned sz = m_size(ty);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ty, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned sz = m_size(ty);
        logic [31:0] v;
        if (sz == 4) return rd;
        v = (rd >> (8 * (a % 4))) % (1 << (8 * sz));
        if (m_signed(ty) && v >= (1 << (8 * sz - 1))) v = v - (1 << (8 * sz));
        return v;
    endfunction

    task automatic go_idle();
        mem_we = 1'b0; mem_rd = 1'b0; dbus_ack = 1'b0;
    endtask

    // One access. ack_at = number of WAIT cycles before ack (0 = same cycle);
    // anything beyond TMO means the bus never answers.
    task automatic xact(input string name, input bit we, input bit rd, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdv, input int ack_at);
        bit mis, timed_out, is_ld;
        int stalls, exp_stalls;
        logic [31:0] exp_rd;
        is_ld = rd && !we;
        mis   = (a % m_size(ty)) != 0;
        @(posedge clk); #1;
        mem_we = we; mem_rd = rd; mem_type = ty; mem_addr = a; mem_data = d;
        dbus_rdata = rdv; dbus_ack = (ack_at == 0);
        #1;
        if (mis) begin
            chk({name, ".adel"}, mem_adel, is_ld);
            chk({name, ".ades"}, mem_ades, we);
            chk({name, ".req"}, dbus_req, 0);
            chk({name, ".stall"}, mem_stall, 0);
            $display("xact %s: misaligned we=%0b rd=%0b type=%0d addr=%h", name, we, rd, ty, a);
        end else begin
            chk({name, ".addr"}, dbus_addr, a & 32'hFFFF_FFFC);
            chk({name, ".be"}, dbus_be, m_be(ty, a));
            chk({name, ".we"}, dbus_we, we);
            if (we) chk({name, ".wdata"}, dbus_wdata, m_wdata(ty, d));
            stalls = 0;
            for (int k = 0; k <= TMO; k++) begin
                chk({name, ".req"}, dbus_req, 1);
                if (mem_stall === 1'b1) stalls++;
                if (k == ack_at || k == TMO) break;
                @(posedge clk); #1;
                dbus_ack = (k + 1 == ack_at);
                #1;
            end
            timed_out  = (ack_at > TMO);
            exp_stalls = timed_out ? TMO + 1 : ack_at + 1;
            exp_rd     = timed_out ? 32'd0 : m_load(ty, a, rdv);
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            #1;
            chk({name, ".stall_cycles"}, stalls, exp_stalls);
            chk({name, ".done_stall"}, mem_stall, 0);
            chk({name, ".done_req"}, dbus_req, 0);
            chk({name, ".buserr"}, mem_buserr, timed_out);
            if (timed_out || is_ld) chk({name, ".rdata"}, mem_rdata, exp_rd);
            $display("xact %s: we=%0b rd=%0b type=%0d addr=%h ack_at=%0d stalls=%0d rdata=%h buserr=%0b",
                     name, we, rd, ty, a, ack_at, stalls, mem_rdata, mem_buserr);
        end
        @(posedge clk); #1;
        go_idle();
        #1;
        chk({name, ".idle_stall"}, mem_stall, 0);
        chk({name, ".idle_buserr"}, mem_buserr, 0);
    endtask

    initial begin
        rst = 1'b1; mem_addr = 32'h0000_0103; mem_data = 32'h1234_5678;
        mem_we = 1'b1; mem_rd = 1'b1; mem_type = 3'd0;
        dbus_rdata = 32'd0; dbus_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("rst.req", dbus_req, 0);
        chk("rst.stall", mem_stall, 0);
        chk("rst.we", dbus_we, 0);
        chk("rst.addr", dbus_addr, 0);
        chk("rst.wdata", dbus_wdata, 0);
        chk("rst.be", dbus_be, 0);
        chk("rst.ades", mem_ades, 0);
        chk("rst.rdata", mem_rdata, 0);
        chk("rst.buserr", mem_buserr, 0);
        @(posedge clk); #1;
        rst = 1'b0; go_idle();
        $display("xact reset: done");

        xact("word_st",   1, 0, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2);
        xact("byte_s_ld", 0, 1, 3'd3, 32'h0000_0203, 32'h0, 32'h8011_2233, 0);
        chk("byte_s_ld.value", mem_rdata, 32'hFFFF_FF80);
        xact("byte_u_ld", 0, 1, 3'd4, 32'h0000_0203, 32'h0, 32'h8011_2233, 0);
        chk("byte_u_ld.value", mem_rdata, 32'h0000_0080);
        xact("half_st",   1, 0, 3'd2, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 1);
        xact("word_adel", 0, 1, 3'd0, 32'h0000_0101, 32'h0, 32'h0, 0);
        xact("half_ades", 1, 0, 3'd1, 32'h0000_0103, 32'h0, 32'h0, 0);
        xact("both_ades", 1, 1, 3'd0, 32'h0000_0102, 32'h0, 32'h0, 0);
        xact("half_ld",   0, 1, 3'd1, 32'h0000_0042, 32'h0, 32'h9ABC_1234, 3);
        xact("timeout",   0, 1, 3'd0, 32'h0000_0400, 32'h0, 32'h5555_AAAA, 99);
        xact("ack_last",  0, 1, 3'd0, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, TMO);

        // Reset lands in the second WAIT cycle with a simultaneous ack
        @(posedge clk); #1;
        mem_we = 1'b0; mem_rd = 1'b1; mem_type = 3'd0; mem_addr = 32'h0000_0500;
        dbus_rdata = 32'hCAFE_0001; dbus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; dbus_ack = 1'b1;
        #1;
        chk("midrst.req", dbus_req, 0);
        chk("midrst.stall", mem_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0; go_idle();
        #1;
        chk("midrst.after_stall", mem_stall, 0);
        chk("midrst.rdata", mem_rdata, 0);
        $display("xact midrst: rdata=%h stall=%0b", mem_rdata, mem_stall);
        xact("post_rst",  0, 1, 3'd4, 32'h0000_0601, 32'h0, 32'h00C3_0000, 1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [2:0]  ty;
            logic [31:0] a;
            op = 2'($urandom_range(1, 3));
            ty = 3'($urandom_range(0, 7));
            a  = $urandom;
            xact($sformatf("rnd%0d", n), op[0], op[1], ty, a, $urandom, $urandom,
                 $urandom_range(0, TMO + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
